// File: rtl/picosoc_timer_if.sv
// picosoc_timer_if
// Bundles the PicoSoC iomem request/response signals.
//   master : initiator side (drives valid/wstrb/addr/wdata, receives ready/rdata)
//   slave  : responder side (receives the request, drives ready/rdata)
interface picosoc_timer_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid,
        output iomem_wstrb,
        output iomem_addr,
        output iomem_wdata,
        input  iomem_ready,
        input  iomem_rdata
    );

    modport slave (
        input  iomem_valid,
        input  iomem_wstrb,
        input  iomem_addr,
        input  iomem_wdata,
        output iomem_ready,
        output iomem_rdata
    );
endinterface

// File: rtl/picosoc_timer.sv
// picosoc_timer
// Prescaled 32-bit up-counter with compare match, overflow flag and level
// interrupt, mapped as a 256-byte register window on the PicoSoC iomem bus.
// Ports:
//   clk    : single clock, all state on the rising edge
//   reset  : asynchronous, active-high reset
//   bus    : iomem responder (valid/wstrb/addr/wdata in, ready/rdata out)
//   irq    : level interrupt = CTRL.IRQ_EN & STATUS.MATCH
// Register map (addr[7:2]): 0x00 CTRL {IRQ_EN,AUTO_RELOAD,EN}, 0x04 PRESC[15:0],
//   0x08 COUNT, 0x0C CMP, 0x10 STATUS {OVF,MATCH} (write-1-to-clear).
module picosoc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic              clk,
    input  logic              reset,
    picosoc_timer_if.slave    bus,
    output logic              irq
);

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_PRESC  = 6'h01;
    localparam logic [5:0] OFF_COUNT  = 6'h02;
    localparam logic [5:0] OFF_CMP    = 6'h03;
    localparam logic [5:0] OFF_STATUS = 6'h04;

    logic [2:0]  ctrl_reg,   ctrl_next;
    logic [15:0] presc_reg,  presc_next;
    logic [31:0] count_reg,  count_next;
    logic [31:0] cmp_reg,    cmp_next;
    logic [1:0]  status_reg, status_next;
    logic [15:0] pc_reg,     pc_next;
    logic        ready_reg,  ready_next;
    logic [31:0] rdata_reg,  rdata_next;

    logic        sel;
    logic        accept;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  off;
    logic [31:0] wmask;
    logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic        tick;
    logic        count_tick;
    logic        match;
    logic        reload;
    logic        carry;
    logic [31:0] count_inc;
    logic [1:0]  status_set;
    logic [1:0]  status_clr;
    logic [31:0] rd_mux;

    // Byte offsets within a word are irrelevant; only word offsets decode.
    wire unused_addr = &{1'b0, bus.iomem_addr[1:0]};

    // Per-byte write mask from the strobes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{bus.iomem_wstrb[gi]}};
        end
    endgenerate

    always_comb begin
        sel    = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
        // A request is taken only while ready is low, so ready never repeats
        // on consecutive cycles.
        accept = sel && !ready_reg;
        wr_en  = accept && (bus.iomem_wstrb != 4'b0000);
        rd_en  = accept && (bus.iomem_wstrb == 4'b0000);
        off    = bus.iomem_addr[7:2];

        wr_ctrl   = wr_en && (off == OFF_CTRL);
        wr_presc  = wr_en && (off == OFF_PRESC);
        wr_count  = wr_en && (off == OFF_COUNT);
        wr_cmp    = wr_en && (off == OFF_CMP);
        wr_status = wr_en && (off == OFF_STATUS);

        tick       = ctrl_reg[0] && (pc_reg == presc_reg);
        // A bus write to COUNT overrides the tick entirely, flags included.
        count_tick = tick && !wr_count;
        match      = (count_reg == cmp_reg);
        reload     = match && ctrl_reg[1];
        {carry, count_inc} = {1'b0, count_reg} + 33'd1;
    end

    always_comb begin
        ctrl_next  = ctrl_reg;
        presc_next = presc_reg;
        cmp_next   = cmp_reg;
        count_next = count_reg;
        status_set = 2'b00;
        status_clr = 2'b00;

        if (wr_ctrl && bus.iomem_wstrb[0]) begin
            ctrl_next = bus.iomem_wdata[2:0];
        end
        if (wr_presc) begin
            presc_next = (presc_reg & ~wmask[15:0]) | (bus.iomem_wdata[15:0] & wmask[15:0]);
        end
        if (wr_cmp) begin
            cmp_next = (cmp_reg & ~wmask) | (bus.iomem_wdata & wmask);
        end
        if (wr_status && bus.iomem_wstrb[0]) begin
            status_clr = bus.iomem_wdata[1:0];
        end

        if (wr_count) begin
            count_next = (count_reg & ~wmask) | (bus.iomem_wdata & wmask);
        end else if (count_tick) begin
            count_next = reload ? 32'd0 : count_inc;
            status_set = {carry && !reload, match};
        end

        // Set wins over a simultaneous clear.
        status_next = (status_reg & ~status_clr) | status_set;

        if (!ctrl_reg[0] || wr_presc || wr_count || tick) begin
            pc_next = 16'd0;
        end else begin
            pc_next = pc_reg + 16'd1;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (off)
            OFF_CTRL:   rd_mux = {29'd0, ctrl_reg};
            OFF_PRESC:  rd_mux = {16'd0, presc_reg};
            OFF_COUNT:  rd_mux = count_reg;
            OFF_CMP:    rd_mux = cmp_reg;
            OFF_STATUS: rd_mux = {30'd0, status_reg};
            default:    rd_mux = 32'd0;
        endcase
        ready_next = accept;
        rdata_next = rd_en ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_reg   <= 3'd0;
            presc_reg  <= 16'd0;
            count_reg  <= 32'd0;
            cmp_reg    <= 32'd0;
            status_reg <= 2'd0;
            pc_reg     <= 16'd0;
            ready_reg  <= 1'b0;
            rdata_reg  <= 32'd0;
        end else begin
            ctrl_reg   <= ctrl_next;
            presc_reg  <= presc_next;
            count_reg  <= count_next;
            cmp_reg    <= cmp_next;
            status_reg <= status_next;
            pc_reg     <= pc_next;
            ready_reg  <= ready_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign bus.iomem_ready = ready_reg;
    assign bus.iomem_rdata = rdata_reg;
    assign irq             = ctrl_reg[2] && status_reg[0];

endmodule

// File: tb/tb_picosoc_timer.sv
// tb_picosoc_timer
// Directed scenarios followed by random bus traffic; every cycle the DUT's
// ready/rdata/irq are compared with a behavioural register-level model.
module tb_picosoc_timer;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    picosoc_timer_if bus();

    picosoc_timer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [2:0]  m_ctrl;
    logic [15:0] m_presc;
    logic [31:0] m_count;
    logic [31:0] m_cmp;
    logic [1:0]  m_status;
    int          m_phase;      // cycles elapsed in the current prescaler period
    logic        m_ready;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ctrl = 0; m_presc = 0; m_count = 0; m_cmp = 0; m_status = 0;
        m_phase = 0; m_ready = 0; m_rdata = 0;
    endtask

    function automatic logic [31:0] m_read(input int word);
        case (word)
            0: return {29'd0, m_ctrl};
            1: return {16'd0, m_presc};
            2: return m_count;
            3: return m_cmp;
            4: return {30'd0, m_status};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Advance one clock: predict the effect of the inputs currently on the bus,
    // take the edge, then compare outputs.
    task automatic cyc();
        logic        hit, take, is_wr, tk, cw, pw;
        int          word;
        logic [31:0] d, n_count, n_cmp, n_rdata;
        logic [3:0]  s;
        logic [2:0]  n_ctrl;
        logic [15:0] n_presc;
        logic [1:0]  setb, clr;
        int          n_phase;

        hit   = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE[31:8]);
        take  = hit && !m_ready;
        s     = bus.iomem_wstrb;
        d     = bus.iomem_wdata;
        is_wr = take && (s != 0);
        word  = int'(bus.iomem_addr[7:2]);
        n_rdata = (take && !is_wr) ? m_read(word) : 32'd0;

        // A tick happens when the elapsed phase reaches PRESC.
        tk = m_ctrl[0] && (m_phase == int'(m_presc));
        cw = is_wr && word == 2;
        pw = is_wr && word == 1;

        n_ctrl = m_ctrl; n_presc = m_presc; n_cmp = m_cmp; n_count = m_count;
        setb = 0; clr = 0;
        if (is_wr && word == 0 && s[0]) n_ctrl = d[2:0];
        if (pw) n_presc = merge({16'd0, m_presc}, d, s & 4'b0011) & 32'hFFFF;
        if (is_wr && word == 3) n_cmp = merge(m_cmp, d, s);
        if (is_wr && word == 4 && s[0]) clr = d[1:0];
        if (cw) begin
            n_count = merge(m_count, d, s);
        end else if (tk) begin
            if (m_count == m_cmp) begin
                setb[0] = 1;
                n_count = m_ctrl[1] ? 32'd0 : m_count + 1;
            end else begin
                n_count = m_count + 1;
            end
            if (m_count == 32'hFFFF_FFFF && !(m_count == m_cmp && m_ctrl[1])) setb[1] = 1;
        end

        if (!m_ctrl[0] || cw || pw || tk) n_phase = 0;
        else n_phase = m_phase + 1;

        @(posedge clk);
        m_ctrl = n_ctrl; m_presc = n_presc; m_cmp = n_cmp; m_count = n_count;
        m_status = (m_status & ~clr) | setb;
        m_phase = n_phase;
        m_ready = take;
        m_rdata = n_rdata;
        #1;
        check("cyc_ready", 32'(bus.iomem_ready), 32'(m_ready));
        check("cyc_rdata", bus.iomem_rdata, m_rdata);
        check("cyc_irq", 32'(irq), 32'(m_ctrl[2] && m_status[0]));
    endtask

    task automatic wr(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s);
        bus.iomem_valid = 1; bus.iomem_addr = BASE | 32'(o);
        bus.iomem_wdata = d; bus.iomem_wstrb = s;
        cyc();
        bus.iomem_valid = 0; bus.iomem_wstrb = 0;
        cyc();
    endtask

    task automatic rd(input logic [7:0] o, output logic [31:0] d);
        bus.iomem_valid = 1; bus.iomem_addr = BASE | 32'(o);
        bus.iomem_wdata = 0; bus.iomem_wstrb = 0;
        cyc();
        d = bus.iomem_rdata;
        bus.iomem_valid = 0;
        cyc();
    endtask

    initial begin
        logic [31:0] v;
        int n;

        bus.iomem_valid = 0; bus.iomem_addr = 0; bus.iomem_wdata = 0; bus.iomem_wstrb = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.iomem_ready), 0);
        check("rst_rdata", bus.iomem_rdata, 0);
        check("rst_irq", 32'(irq), 0);
        reset = 0;

        // Read CMP after reset: ready one cycle later, then low.
        bus.iomem_valid = 1; bus.iomem_addr = BASE + 32'h0C; bus.iomem_wstrb = 0;
        cyc();
        check("rd_ready_hi", 32'(bus.iomem_ready), 1);
        check("rd_cmp_zero", bus.iomem_rdata, 0);
        bus.iomem_valid = 0;
        cyc();
        check("rd_ready_lo", 32'(bus.iomem_ready), 0);

        // Prescaled counting with auto-reload and interrupt.
        wr(8'h04, 32'd3, 4'hF);
        wr(8'h0C, 32'd5, 4'hF);
        wr(8'h00, 32'h7, 4'hF);
        n = 0;
        while (irq !== 1'b1 && n < 200) begin cyc(); n++; end
        check("match_latency", 32'(n), 23);
        rd(8'h08, v); check("count_reloaded", v, 0);
        rd(8'h10, v); check("status_match", v, 1);
        check("irq_on", 32'(irq), 1);

        // Write-1-to-clear.
        wr(8'h10, 32'h1, 4'h1);
        check("irq_cleared", 32'(irq), 0);
        rd(8'h10, v); check("status_cleared", v, 0);

        // Clear coinciding with a match tick: match must stay set.
        n = 0;
        while (!(m_ctrl[0] && m_phase == int'(m_presc) && m_count == m_cmp) && n < 200) begin
            cyc(); n++;
        end
        check("wait_match_tick", 32'(n < 200), 1);
        wr(8'h10, 32'h1, 4'h1);
        rd(8'h10, v); check("set_beats_clear", v, 1);
        check("irq_still_on", 32'(irq), 1);

        // Overflow wrap with PRESC=0 and IRQ disabled.
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h08, 32'hFFFF_FFFF, 4'hF);
        wr(8'h0C, 32'h0, 4'hF);
        wr(8'h04, 32'h0, 4'h3);
        wr(8'h10, 32'h3, 4'h1);
        wr(8'h00, 32'h1, 4'h1);
        rd(8'h10, v); check("ovf_only", v, 2);
        rd(8'h10, v); check("ovf_and_match", v, 3);
        check("irq_disabled", 32'(irq), 0);

        // Byte-lane write and unmapped accesses.
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h0C, 32'h1234_5678, 4'hF);
        wr(8'h0C, 32'h0000_AB00, 4'b0010);
        rd(8'h0C, v); check("byte_write", v, 32'h1234_AB78);
        rd(8'h18, v); check("unmapped_read", v, 0);
        bus.iomem_valid = 1; bus.iomem_addr = BASE + 32'h100; bus.iomem_wstrb = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("oow_no_ready", 32'(bus.iomem_ready), 0);
        end
        bus.iomem_valid = 0;
        cyc();

        // Reset during a write's wait cycle.
        bus.iomem_valid = 1; bus.iomem_addr = BASE + 32'h0C;
        bus.iomem_wdata = 32'hDEAD_BEEF; bus.iomem_wstrb = 4'hF;
        #1;
        reset = 1;
        #1;
        model_reset();
        check("midrst_ready", 32'(bus.iomem_ready), 0);
        check("midrst_rdata", bus.iomem_rdata, 0);
        check("midrst_irq", 32'(irq), 0);
        @(posedge clk);
        #1;
        check("midrst_ready_edge", 32'(bus.iomem_ready), 0);
        bus.iomem_valid = 0; bus.iomem_wstrb = 0;
        reset = 0;
        cyc();
        rd(8'h0C, v); check("midrst_cmp", v, 0);

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            logic [7:0]  o;
            logic [31:0] d;
            logic [3:0]  s;
            o = 8'($urandom_range(0, 6)) << 2;
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.iomem_valid = 1;
            bus.iomem_addr  = ($urandom_range(0, 9) == 0) ? (BASE + 32'h100 + 32'(o)) : (BASE + 32'(o));
            bus.iomem_wdata = d;
            bus.iomem_wstrb = s;
            cyc();
            bus.iomem_valid = 0; bus.iomem_wstrb = 0;
            repeat (1 + $urandom_range(0, 5)) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
